pxl_write_arbiter: RTL and testbench
====================================

PXL_WRITE_ARBITER -- requirements
Module: pxl_write_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, number of pixel-write requesters (legal range 2..4).
REQ-002 The block SHALL have parameter ADDR_W, default 20, pixel address width.
REQ-003 The block SHALL have parameter DATA_W, default 16, pixel data width.
REQ-004 The block SHALL have parameter BURST_MAX, default 16, max consecutive accepts per grant when another requester waits.
REQ-005 The block SHALL have ports clk_i  in  1  single clock (pixel-write domain), driving all logic.
REQ-006 The block SHALL have ports rst_n_i  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have ports req_valid_i  in  NREQ  per-requester write valid.
REQ-008 The block SHALL have ports req_addr_i  in  NREQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have ports req_data_i  in  NREQ*DATA_W  packed pixel data, same packing.
REQ-010 The block SHALL have ports req_ready_o  out  NREQ  per-requester accept.
REQ-011 The block SHALL have ports vblank_i  in  1  vertical-blank indicator from the video timing path.
REQ-012 The block SHALL have ports pxl_addr_o  out  ADDR_W, pxl_data_o  out  DATA_W, pxl_en_o  out  1: framebuffer write port.
REQ-013 The block SHALL have ports grant_o  out  NREQ  one-hot current owner (zero when idle); busy_o  out  1  state is GRANT.

Function
REQ-014 FSM states SHALL be IDLE and GRANT.
REQ-015 In IDLE, if any req_valid_i is high, the block SHALL pick owner by round-robin: first valid index after last_owner, wrapping NREQ-1 -> 0, and enter GRANT next cycle.
REQ-016 req_ready_o[i] SHALL be high only when state is GRANT and i is owner; it SHALL be zero for all others.
REQ-017 A transfer SHALL occur when req_valid_i[owner] and req_ready_o[owner] are both high on a rising edge.
REQ-018 Each transfer SHALL produce pxl_en_o=1 with the transferred addr/data on pxl_addr_o/pxl_data_o exactly one cycle later (registered, latency 1); pxl_en_o SHALL be 0 otherwise, addr/data held.
REQ-019 A burst counter SHALL count transfers in the current GRANT and reset to 0 on entering GRANT.
REQ-020 GRANT SHALL return to IDLE when the owner's valid is low, or when the counter reaches BURST_MAX and any other requester's valid is high; the last_owner SHALL then be updated to the owner.
REQ-021 When counter reaches BURST_MAX with no other requester valid, the owner SHALL retain the grant and the counter SHALL saturate.
REQ-022 A deasserted valid from a non-owner SHALL have no effect; simultaneous valids in IDLE SHALL resolve purely by round-robin order.
REQ-023 Arbitration SHALL cost exactly one IDLE cycle between grants (no zero-cycle handover).

Reset
REQ-024 On rst_n_i low: state IDLE, last_owner=NREQ-1 (requester 0 wins first), counter 0, pxl_en_o 0, pxl_addr_o 0, pxl_data_o 0, req_ready_o 0, grant_o 0, busy_o 0.
REQ-025 Reset asserted mid-burst SHALL drop the in-flight write (pxl_en_o forced 0 immediately) with no partial output.

Configuration
REQ-026 With macro PXL_ARB_VBLANK_ONLY_EN defined, IDLE->GRANT SHALL additionally require vblank_i=1, and in GRANT vblank_i=0 SHALL force req_ready_o to 0 that cycle and return to IDLE.
REQ-027 Without PXL_ARB_VBLANK_ONLY_EN, vblank_i SHALL be ignored (port retained).

Structure
REQ-028 A shared package pxl_arb_pkg SHALL hold the state enum and default ADDR_W/DATA_W constants.
REQ-029 The round-robin priority pick SHALL be a combinational sub-module rr_picker (inputs valid vector, last index; output one-hot and index).

Verification
REQ-030 Reset then req0 valid, addr 0x00010, data 0xABCD -> grant next cycle, ready high, pxl_en_o=1 with 0x00010/0xABCD one cycle after accept.
REQ-031 req0 and req1 valid together from reset -> req0 granted first; after req0 drops, one IDLE cycle, then req1 granted.
REQ-032 req0 and req1 continuously valid, BURST_MAX=16 -> exactly 16 req0 writes, 1 idle cycle, 16 req1 writes, alternating.
REQ-033 Only req1 valid for 40 cycles -> grant held, 39 writes (first cycle IDLE), counter saturates, no IDLE gaps.
REQ-034 rst_n_i pulsed low mid-burst -> pxl_en_o 0 asynchronously, all outputs at reset values, next grant goes to req0.
REQ-035 With PXL_ARB_VBLANK_ONLY_EN, vblank_i falling mid-burst -> ready drops that cycle, state IDLE, no grant until vblank_i high.

Source files
------------

// File: rtl/pxl_arb_pkg.sv
// Shared types and default widths for the pixel-write arbiter.
package pxl_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned PXL_ADDR_W = 20;
    localparam int unsigned PXL_DATA_W = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first valid index after 'last', wrapping.
module rr_picker #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx
);

    int unsigned cand;
    logic        found;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last) + k) % NREQ;
            if (!found && valid[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/pxl_write_arbiter.sv
// Round-robin framebuffer write arbiter with bounded bursts per grant.
// Optional PXL_ARB_VBLANK_ONLY_EN restricts grants to vertical blank.
module pxl_write_arbiter
    import pxl_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned ADDR_W    = PXL_ADDR_W,
    parameter int unsigned DATA_W    = PXL_DATA_W,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*ADDR_W-1:0] req_addr_i,
    input  logic [NREQ*DATA_W-1:0] req_data_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic                   vblank_i,
    output logic [ADDR_W-1:0]      pxl_addr_o,
    output logic [DATA_W-1:0]      pxl_data_o,
    output logic                   pxl_en_o,
    output logic [NREQ-1:0]        grant_o,
    output logic                   busy_o
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [0:0]  IDLE  = 1'(ST_IDLE);
    localparam logic [0:0]  GRANT = 1'(ST_GRANT);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic [NREQ-1:0]  pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             vb_ok;
    logic             owner_valid;
    logic             others_valid;

`ifdef PXL_ARB_VBLANK_ONLY_EN
    assign vb_ok = vblank_i;
`else
    logic unused_vblank;
    assign unused_vblank = vblank_i;
    assign vb_ok         = 1'b1;
`endif

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .valid  (req_valid_i),
        .last   (last_q),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign owner_valid  = req_valid_i[owner_q];
    assign others_valid = |(req_valid_i & ~grant_q);
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == GRANT);

    // Next-state, burst accounting and write-port capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        en_d        = 1'b0;
        addr_d      = pxl_addr_o;
        data_d      = pxl_data_o;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if ((|req_valid_i) && vb_ok) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    grant_d = pick_oh;
                    cnt_d   = '0;
                end
            end
            default: begin
                req_ready_o = grant_q & {NREQ{vb_ok}};
                if (!vb_ok || !owner_valid) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else begin
                    en_d   = 1'b1;
                    addr_d = req_addr_i[int'(owner_q) * int'(ADDR_W) +: ADDR_W];
                    data_d = req_data_i[int'(owner_q) * int'(DATA_W) +: DATA_W];
                    if (cnt_q < CNT_W'(BURST_MAX))
                        cnt_d = cnt_q + CNT_W'(1);
                    // The transfer that fills the burst is the last one if someone waits
                    if ((cnt_q >= CNT_W'(BURST_MAX - 1)) && others_valid) begin
                        state_d = IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= IDX_W'(NREQ - 1);
            grant_q    <= '0;
            cnt_q      <= '0;
            pxl_en_o   <= 1'b0;
            pxl_addr_o <= '0;
            pxl_data_o <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            pxl_en_o   <= en_d;
            pxl_addr_o <= addr_d;
            pxl_data_o <= data_d;
        end
    end

endmodule

// File: tb/tb_pxl_write_arbiter.sv
// Directed self-checking bench for pxl_write_arbiter (default build, NREQ=2).
module tb_pxl_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  valid;
    logic [39:0] addr;
    logic [31:0] data;
    logic [1:0]  ready;
    logic        vblank;
    logic [19:0] pxl_addr;
    logic [15:0] pxl_data;
    logic        pxl_en;
    logic [1:0]  grant;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    pxl_write_arbiter #(
        .NREQ      (2),
        .ADDR_W    (20),
        .DATA_W    (16),
        .BURST_MAX (16)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (valid),
        .req_addr_i  (addr),
        .req_data_i  (data),
        .req_ready_o (ready),
        .vblank_i    (vblank),
        .pxl_addr_o  (pxl_addr),
        .pxl_data_o  (pxl_data),
        .pxl_en_o    (pxl_en),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling/driving
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int en_cnt;
    int busy_cnt;
    logic [16:0] exp_w;
    logic [16:0] got_w;

    initial begin
        rst_n  = 1'b0;
        valid  = '0;
        addr   = '0;
        data   = '0;
        vblank = 1'b0;
        do_reset();

        // Reset values
        check_eq("rst_en",    32'(pxl_en),   32'h0);
        check_eq("rst_addr",  32'(pxl_addr), 32'h0);
        check_eq("rst_data",  32'(pxl_data), 32'h0);
        check_eq("rst_ready", 32'(ready),    32'h0);
        check_eq("rst_grant", 32'(grant),    32'h0);
        check_eq("rst_busy",  32'(busy),     32'h0);

        // Single write from requester 0
        valid = 2'b01;
        addr  = {20'h0, 20'h00010};
        data  = {16'h0, 16'hABCD};
        tick();
        check_eq("t1_grant", 32'(grant),  32'h1);
        check_eq("t1_ready", 32'(ready),  32'h1);
        check_eq("t1_busy",  32'(busy),   32'h1);
        check_eq("t1_en0",   32'(pxl_en), 32'h0);
        tick();
        check_eq("t1_en",   32'(pxl_en),   32'h1);
        check_eq("t1_addr", 32'(pxl_addr), 32'h00010);
        check_eq("t1_data", 32'(pxl_data), 32'hABCD);
        valid = 2'b00;
        tick();
        check_eq("t1_idle_en",   32'(pxl_en),   32'h0);
        check_eq("t1_idle_busy", 32'(busy),     32'h0);
        check_eq("t1_hold_addr", 32'(pxl_addr), 32'h00010);
        check_eq("t1_hold_data", 32'(pxl_data), 32'hABCD);

        // Simultaneous valids: req0 first, one IDLE cycle, then req1
        do_reset();
        valid = 2'b11;
        tick();
        check_eq("t2_grant0", 32'(grant), 32'h1);
        check_eq("t2_ready0", 32'(ready), 32'h1);
        tick();
        tick();
        valid = 2'b10;
        tick();
        check_eq("t2_gap_busy",  32'(busy),  32'h0);
        check_eq("t2_gap_grant", 32'(grant), 32'h0);
        check_eq("t2_gap_ready", 32'(ready), 32'h0);
        tick();
        check_eq("t2_grant1", 32'(grant), 32'h2);
        check_eq("t2_ready1", 32'(ready), 32'h2);

        // Both continuously valid: 16 writes each, alternating, one idle cycle between
        do_reset();
        addr  = {20'h22222, 20'h11111};
        data  = {16'hB000, 16'hA000};
        valid = 2'b11;
        tick();
        for (int c = 2; c <= 60; c++) begin
            tick();
            if (((c - 2) % 17) == 16)
                exp_w = 17'h0;
            else
                exp_w = (((c - 2) / 17) % 2 == 0) ? {1'b1, 16'hA000} : {1'b1, 16'hB000};
            got_w = pxl_en ? {1'b1, pxl_data} : 17'h0;
            check_eq($sformatf("t3_c%0d", c), 32'(got_w), 32'(exp_w));
        end

        // Only req1 for 40 cycles: grant held, 39 writes, saturating counter
        do_reset();
        valid    = 2'b10;
        en_cnt   = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 41; c++) begin
            if (c == 41) valid = 2'b00;
            tick();
            if (pxl_en) en_cnt++;
            if (busy && c <= 40) busy_cnt++;
        end
        check_eq("t4_writes", 32'(en_cnt),   32'd39);
        check_eq("t4_busy",   32'(busy_cnt), 32'd40);

        // Reset mid-burst of req1: outputs cleared immediately, req0 wins next
        do_reset();
        valid = 2'b10;
        tick();
        tick();
        tick();
        check_eq("t5_pre_en", 32'(pxl_en), 32'h1);
        valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check_eq("t5_en",    32'(pxl_en),   32'h0);
        check_eq("t5_addr",  32'(pxl_addr), 32'h0);
        check_eq("t5_data",  32'(pxl_data), 32'h0);
        check_eq("t5_grant", 32'(grant),    32'h0);
        check_eq("t5_ready", 32'(ready),    32'h0);
        check_eq("t5_busy",  32'(busy),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("t5_regrant", 32'(grant), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
